// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline.
// Controls are Mealy outputs of the RUN/MEM_WAIT state and the live hazard
// inputs, so a hazard is answered in the same cycle it appears.
module pipe_hazard_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             pipe_hold,
   output logic             memwb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} fsm_t;

   localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   fsm_t             fsm_q, fsm_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic lu_hazard;
   logic timeout_now;
   logic mem_stall;

   // Hazard conditions; a timeout only counts while the access is still requested.
   always_comb begin
      lu_hazard   = ex_MemRead && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      timeout_now = (fsm_q == MEM_WAIT) && mem_req && (wait_cnt_q == WAIT_LAST) && !mem_ready;
      mem_stall   = mem_req && !mem_ready && !timeout_now;
   end

   // State, wait counter, timeout pulse and stall counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q         <= RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         fsm_q         <= fsm_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   // Next-state logic for the memory-wait FSM and the counters.
   always_comb begin
      fsm_d         = fsm_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = timeout_now;
      stall_cnt_d   = stall_cnt_q;
      case (fsm_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               fsm_d      = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (!mem_req || mem_ready || timeout_now) begin
               fsm_d      = RUN;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            fsm_d      = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
      if (!pc_write && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // Prioritised stage-register controls; reset forces a frozen, bubbling pipe.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      pipe_hold    = 1'b0;
      memwb_bubble = 1'b0;
      if (rst) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         memwb_bubble = 1'b1;
      end else if (mem_stall) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         pipe_hold    = 1'b1;
         memwb_bubble = 1'b1;
      end else if (timeout_now) begin
         memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
      end else if (lu_hazard) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_flush   = 1'b1;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_cnt   = stall_cnt_q;

endmodule
